// File: rtl/isect_pkg.sv
// Shared types and constants for the ray/triangle intersection scheduler.
package isect_pkg;

    localparam int unsigned FX_W = 32;
    localparam logic signed [FX_W-1:0] T_MAX = 32'sh7FFFFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/isect_best_tracker.sv
// Tracks the closest valid hit of a job plus a sticky flag for invalid results.
module isect_best_tracker
    import isect_pkg::*;
#(
    parameter int unsigned IDX_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_clear,
    input  logic                    i_sample,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic                    i_result,
    input  logic                    i_invalid,
    input  logic signed [FX_W-1:0]  i_t,
    output logic                    o_best_valid,
    output logic [IDX_W-1:0]        o_best_idx,
    output logic signed [FX_W-1:0]  o_best_t,
    output logic                    o_any_invalid
);

    logic take;

    // Strict compare: results arrive in index order, so ties keep the lower index.
    always_comb begin
        take = i_sample && i_result && !i_invalid &&
               (!o_best_valid || (i_t < o_best_t));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_best_valid  <= 1'b0;
            o_best_idx    <= '0;
            o_best_t      <= T_MAX;
            o_any_invalid <= 1'b0;
        end else if (i_clear) begin
            o_best_valid  <= 1'b0;
            o_best_idx    <= '0;
            o_best_t      <= T_MAX;
            o_any_invalid <= 1'b0;
        end else begin
            if (take) begin
                o_best_valid <= 1'b1;
                o_best_idx   <= i_idx;
                o_best_t     <= i_t;
            end
            if (i_sample && i_invalid) begin
                o_any_invalid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/isect_sched.sv
// Issues triangle reads for one ray job and reports the closest hit.
// Define ISECT_SCHED_STATS_EN to add the o_job_cycles statistics output.
module isect_sched
    import isect_pkg::*;
#(
    parameter int unsigned TRI_IDX_W = 16,
    parameter int unsigned MEM_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_ray_valid,
    output logic                          o_ray_ready,
    input  logic signed [31:0][1:0][2:0]  i_ray,
    input  logic [TRI_IDX_W-1:0]          i_num_tris,
    output logic signed [31:0][1:0][2:0]  o_ray,
    output logic                          o_tri_rd,
    output logic [TRI_IDX_W-1:0]          o_tri_addr,
    input  logic                          i_isect_result,
    input  logic                          i_isect_invalid,
    input  logic signed [FX_W-1:0]        i_isect_t,
    output logic                          o_hit_valid,
    input  logic                          i_hit_ready,
    output logic                          o_hit,
    output logic [TRI_IDX_W-1:0]          o_hit_idx,
    output logic signed [FX_W-1:0]        o_hit_t,
    output logic                          o_any_invalid
`ifdef ISECT_SCHED_STATS_EN
    ,
    output logic [31:0]                   o_job_cycles
`endif
);

    localparam int unsigned DRAIN_W = 3;

    state_t                         state, state_n;
    logic [TRI_IDX_W-1:0]           num_tris, num_tris_n;
    logic [DRAIN_W-1:0]             drain_cnt, drain_cnt_n;
    logic signed [31:0][1:0][2:0]   ray_n;
    logic                           tri_rd_n;
    logic [TRI_IDX_W-1:0]           tri_addr_n;
    logic                           ray_ready_n;
    logic                           hit_valid_n;
    logic                           hit_n;
    logic [TRI_IDX_W-1:0]           hit_idx_n;
    logic signed [FX_W-1:0]         hit_t_n;
    logic                           any_invalid_n;
    logic                           accept;

    logic                           tag_v   [MEM_LAT];
    logic [TRI_IDX_W-1:0]           tag_idx [MEM_LAT];

    logic                           best_valid;
    logic [TRI_IDX_W-1:0]           best_idx;
    logic signed [FX_W-1:0]         best_t;
    logic                           best_invalid;

    // Next-state and next-output logic.
    always_comb begin
        state_n       = state;
        num_tris_n    = num_tris;
        drain_cnt_n   = drain_cnt;
        ray_n         = o_ray;
        tri_rd_n      = 1'b0;
        tri_addr_n    = o_tri_addr;
        hit_valid_n   = o_hit_valid;
        hit_n         = o_hit;
        hit_idx_n     = o_hit_idx;
        hit_t_n       = o_hit_t;
        any_invalid_n = o_any_invalid;
        accept        = 1'b0;

        case (state)
            IDLE: begin
                if (i_ray_valid) begin
                    accept     = 1'b1;
                    ray_n      = i_ray;
                    num_tris_n = i_num_tris;
                    tri_addr_n = '0;
                    if (i_num_tris != '0) begin
                        state_n  = ISSUE;
                        tri_rd_n = 1'b1;
                    end else begin
                        state_n  = DONE;
                    end
                end
            end
            ISSUE: begin
                // Stop on the last index so the counter never wraps.
                if (o_tri_addr == num_tris - TRI_IDX_W'(1)) begin
                    state_n     = DRAIN;
                    drain_cnt_n = '0;
                end else begin
                    tri_rd_n   = 1'b1;
                    tri_addr_n = o_tri_addr + TRI_IDX_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_W'(MEM_LAT - 1)) begin
                    state_n = DONE;
                end else begin
                    drain_cnt_n = drain_cnt + DRAIN_W'(1);
                end
            end
            DONE: begin
                // First DONE cycle lets the last sample settle into the tracker.
                if (!o_hit_valid) begin
                    hit_valid_n   = 1'b1;
                    hit_n         = best_valid;
                    hit_idx_n     = best_idx;
                    hit_t_n       = best_t;
                    any_invalid_n = best_invalid;
                end else if (i_hit_ready) begin
                    hit_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        ray_ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            num_tris      <= '0;
            drain_cnt     <= '0;
            o_ray         <= '0;
            o_ray_ready   <= 1'b1;
            o_tri_rd      <= 1'b0;
            o_tri_addr    <= '0;
            o_hit_valid   <= 1'b0;
            o_hit         <= 1'b0;
            o_hit_idx     <= '0;
            o_hit_t       <= T_MAX;
            o_any_invalid <= 1'b0;
        end else begin
            state         <= state_n;
            num_tris      <= num_tris_n;
            drain_cnt     <= drain_cnt_n;
            o_ray         <= ray_n;
            o_ray_ready   <= ray_ready_n;
            o_tri_rd      <= tri_rd_n;
            o_tri_addr    <= tri_addr_n;
            o_hit_valid   <= hit_valid_n;
            o_hit         <= hit_n;
            o_hit_idx     <= hit_idx_n;
            o_hit_t       <= hit_t_n;
            o_any_invalid <= any_invalid_n;
        end
    end

    // Read tags travel alongside the memory latency to qualify returning results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MEM_LAT; i++) begin
                tag_v[i]   <= 1'b0;
                tag_idx[i] <= '0;
            end
        end else begin
            tag_v[0]   <= o_tri_rd;
            tag_idx[0] <= o_tri_addr;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    isect_best_tracker #(
        .IDX_W (TRI_IDX_W)
    ) u_best (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (accept),
        .i_sample      (tag_v[MEM_LAT-1]),
        .i_idx         (tag_idx[MEM_LAT-1]),
        .i_result      (i_isect_result),
        .i_invalid     (i_isect_invalid),
        .i_t           (i_isect_t),
        .o_best_valid  (best_valid),
        .o_best_idx    (best_idx),
        .o_best_t      (best_t),
        .o_any_invalid (best_invalid)
    );

`ifdef ISECT_SCHED_STATS_EN
    // Cycles spent in ISSUE and DRAIN, i.e. accept up to the first DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_job_cycles <= '0;
        end else if (accept) begin
            o_job_cycles <= '0;
        end else if ((state == ISSUE || state == DRAIN) && (o_job_cycles != '1)) begin
            o_job_cycles <= o_job_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_isect_sched.sv
// Directed self-checking bench for isect_sched with a one-cycle triangle memory model.
module tb_isect_sched;

    localparam int unsigned W  = 16;
    localparam int unsigned ML = 1;
    localparam logic signed [31:0] TMAX = 32'sh7FFFFFFF;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         i_ray_valid;
    logic                         o_ray_ready;
    logic signed [31:0][1:0][2:0] i_ray;
    logic [W-1:0]                 i_num_tris;
    logic signed [31:0][1:0][2:0] o_ray;
    logic                         o_tri_rd;
    logic [W-1:0]                 o_tri_addr;
    logic                         i_isect_result;
    logic                         i_isect_invalid;
    logic signed [31:0]           i_isect_t;
    logic                         o_hit_valid;
    logic                         i_hit_ready;
    logic                         o_hit;
    logic [W-1:0]                 o_hit_idx;
    logic signed [31:0]           o_hit_t;
    logic                         o_any_invalid;

    int checks = 0;
    int failures = 0;

    logic [15:0]                  res_tab;
    logic [15:0]                  inv_tab;
    logic signed [31:0]           t_tab [16];
    logic                         rd_d = 1'b0;
    logic [W-1:0]                 addr_d = '0;

    logic signed [31:0][1:0][2:0] cur_ray;
    int                           nrd;
    logic                         seq_ok;
    logic                         ray_ok;
    int                           job_id = 0;

    isect_sched #(
        .TRI_IDX_W (W),
        .MEM_LAT   (ML)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_ray_valid     (i_ray_valid),
        .o_ray_ready     (o_ray_ready),
        .i_ray           (i_ray),
        .i_num_tris      (i_num_tris),
        .o_ray           (o_ray),
        .o_tri_rd        (o_tri_rd),
        .o_tri_addr      (o_tri_addr),
        .i_isect_result  (i_isect_result),
        .i_isect_invalid (i_isect_invalid),
        .i_isect_t       (i_isect_t),
        .o_hit_valid     (o_hit_valid),
        .i_hit_ready     (i_hit_ready),
        .o_hit           (o_hit),
        .o_hit_idx       (o_hit_idx),
        .o_hit_t         (o_hit_t),
        .o_any_invalid   (o_any_invalid)
    );

    always #5 clk = ~clk;

    // Memory returns the addressed result one cycle after the read strobe.
    always @(posedge clk) begin
        rd_d   <= o_tri_rd;
        addr_d <= o_tri_addr;
    end

    // Untagged cycles carry a poisoned result that must be ignored.
    always_comb begin
        if (rd_d) begin
            if (addr_d < W'(16)) begin
                i_isect_result  = res_tab[addr_d[3:0]];
                i_isect_invalid = inv_tab[addr_d[3:0]];
                i_isect_t       = t_tab[addr_d[3:0]];
            end else begin
                i_isect_result  = (addr_d == 16'hFFFE);
                i_isect_invalid = 1'b0;
                i_isect_t       = 32'sd7;
            end
        end else begin
            i_isect_result  = 1'b1;
            i_isect_invalid = 1'b1;
            i_isect_t       = -32'sd1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_tab();
        res_tab = '0;
        inv_tab = '0;
        for (int i = 0; i < 16; i++) t_tab[i] = 32'sd1000;
    endtask

    task automatic set_entry(input int idx, input logic res, input logic inv, input logic signed [31:0] t);
        res_tab[idx] = res;
        inv_tab[idx] = inv;
        t_tab[idx]   = t;
    endtask

    task automatic observe();
        if (o_tri_rd === 1'b1) begin
            if (o_tri_addr !== W'(nrd)) seq_ok = 1'b0;
            nrd++;
        end
        if (o_ray !== cur_ray || o_ray_ready !== 1'b0) ray_ok = 1'b0;
    endtask

    task automatic run_job(input string name, input int n, input logic exp_hit,
                           input logic [W-1:0] exp_idx, input logic signed [31:0] exp_t,
                           input logic exp_inv, input int hold);
        int    lat;
        int    exp_lat;
        logic  stable_ok;
        job_id++;
        exp_lat = (n == 0) ? 1 : n + int'(ML) + 1;
        @(negedge clk);
        check({name, ":ready_before"}, 64'(o_ray_ready), 64'd1);
        cur_ray     = {6{32'h1357_0000 + 32'(job_id)}};
        i_ray       = cur_ray;
        i_num_tris  = W'(n);
        i_ray_valid = 1'b1;
        @(posedge clk);
        #1;
        i_ray_valid = 1'b0;
        i_ray       = '0;
        i_num_tris  = '0;
        lat = 0; nrd = 0; seq_ok = 1'b1; ray_ok = 1'b1;
        observe();
        while (o_hit_valid !== 1'b1 && lat < 70000) begin
            @(posedge clk);
            #1;
            lat++;
            observe();
        end
        check({name, ":latency"}, 64'(lat), 64'(exp_lat));
        check({name, ":reads"}, 64'(nrd), 64'(n));
        check({name, ":addr_seq"}, 64'(seq_ok), 64'd1);
        check({name, ":ray_busy"}, 64'(ray_ok), 64'd1);
        check({name, ":hit"}, 64'(o_hit), 64'(exp_hit));
        check({name, ":idx"}, 64'(o_hit_idx), 64'(exp_idx));
        check({name, ":t"}, 64'(o_hit_t), 64'(exp_t));
        check({name, ":any_invalid"}, 64'(o_any_invalid), 64'(exp_inv));
        if (hold > 0) begin
            stable_ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (o_hit_valid !== 1'b1 || o_hit !== exp_hit || o_hit_idx !== exp_idx ||
                    o_hit_t !== exp_t || o_any_invalid !== exp_inv ||
                    o_ray_ready !== 1'b0 || o_ray !== cur_ray)
                    stable_ok = 1'b0;
            end
            check({name, ":hold_stable"}, 64'(stable_ok), 64'd1);
        end
        @(negedge clk);
        i_hit_ready = 1'b1;
        @(posedge clk);
        #1;
        i_hit_ready = 1'b0;
        check({name, ":valid_after_take"}, 64'(o_hit_valid), 64'd0);
        check({name, ":ready_after_take"}, 64'(o_ray_ready), 64'd1);
    endtask

    initial begin
        reset       = 1'b1;
        i_ray_valid = 1'b0;
        i_ray       = '0;
        i_num_tris  = '0;
        i_hit_ready = 1'b0;
        cur_ray     = '0;
        clear_tab();
        repeat (3) @(posedge clk);
        #1;
        check("reset:tri_rd", 64'(o_tri_rd), 64'd0);
        check("reset:hit_valid", 64'(o_hit_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset:ready", 64'(o_ray_ready), 64'd1);
        check("reset:tri_rd_rel", 64'(o_tri_rd), 64'd0);
        check("reset:tri_addr", 64'(o_tri_addr), 64'd0);
        check("reset:hit_valid_rel", 64'(o_hit_valid), 64'd0);
        check("reset:hit", 64'(o_hit), 64'd0);
        check("reset:hit_idx", 64'(o_hit_idx), 64'd0);
        check("reset:hit_t", 64'(o_hit_t), 64'(TMAX));
        check("reset:any_invalid", 64'(o_any_invalid), 64'd0);
        check("reset:ray_zero", 64'(o_ray == '0), 64'd1);

        // Closest of two hits, held in DONE for five cycles.
        clear_tab();
        set_entry(1, 1'b1, 1'b0, 32'sd50);
        set_entry(3, 1'b1, 1'b0, 32'sd20);
        run_job("closest", 4, 1'b1, W'(3), 32'sd20, 1'b0, 5);

        // Equal distances keep the lower index.
        clear_tab();
        set_entry(0, 1'b1, 1'b0, 32'sd10);
        set_entry(2, 1'b1, 1'b0, 32'sd10);
        run_job("tie", 3, 1'b1, W'(0), 32'sd10, 1'b0, 0);

        // Negative distances compare signed.
        clear_tab();
        set_entry(0, 1'b1, 1'b0, 32'sd5);
        set_entry(1, 1'b1, 1'b0, -32'sd3);
        set_entry(2, 1'b1, 1'b0, -32'sd3);
        run_job("signed", 3, 1'b1, W'(1), -32'sd3, 1'b0, 0);

        clear_tab();
        run_job("empty", 0, 1'b0, W'(0), TMAX, 1'b0, 0);

        // Invalid hit never wins but is flagged.
        clear_tab();
        set_entry(0, 1'b1, 1'b1, 32'sd5);
        set_entry(1, 1'b1, 1'b0, 32'sd9);
        run_job("invalid", 2, 1'b1, W'(1), 32'sd9, 1'b1, 0);

        clear_tab();
        set_entry(2, 1'b0, 1'b1, 32'sd4);
        run_job("miss_inv", 5, 1'b0, W'(0), TMAX, 1'b1, 0);

        clear_tab();
        run_job("sticky_clear", 1, 1'b0, W'(0), TMAX, 1'b0, 0);

        clear_tab();
        set_entry(0, 1'b1, 1'b0, TMAX);
        run_job("tmax_hit", 1, 1'b1, W'(0), TMAX, 1'b0, 0);

        // Reset in the middle of ISSUE drops the job at once.
        clear_tab();
        set_entry(0, 1'b1, 1'b0, 32'sd1);
        @(negedge clk);
        i_ray       = {6{32'hCAFE_0001}};
        i_num_tris  = W'(10);
        i_ray_valid = 1'b1;
        @(posedge clk);
        #1;
        i_ray_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset:tri_rd", 64'(o_tri_rd), 64'd0);
        check("midreset:ready", 64'(o_ray_ready), 64'd1);
        check("midreset:tri_addr", 64'(o_tri_addr), 64'd0);
        check("midreset:ray_zero", 64'(o_ray == '0), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        clear_tab();
        run_job("after_reset", 1, 1'b0, W'(0), TMAX, 1'b0, 0);

        // Largest count: the last index is issued and the counter does not wrap.
        clear_tab();
        set_entry(5, 1'b1, 1'b0, 32'sd100);
        run_job("max_count", 65535, 1'b1, W'(16'hFFFE), 32'sd7, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
